// File: rtl/fp16_mul_pkg.sv
// Shared types and constants for the fp16 multiplier scheduler.
package fp16_mul_pkg;

  localparam int FP16_W = 16;
  localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESPOND
  } sched_state_t;

endpackage

// File: rtl/fp16_mul_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, with wrap.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  localparam int unsigned NU = N;

  always_comb begin
    int unsigned j;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int unsigned k = 0; k < NU; k++) begin
      j = 32'(ptr) + k;
      if (j >= NU) j = j - NU;
      if (!any && req[IW'(j)]) begin
        any              = 1'b1;
        grant[IW'(j)]    = 1'b1;
        grant_idx        = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fp16_mul_sched.sv
// Round-robin scheduler sharing one fp16 multiplier between NUM_REQ requesters,
// with a watchdog that substitutes a qNaN response when mul_done never arrives.
module fp16_mul_sched
  import fp16_mul_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int TIMEOUT = 15,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [FP16_W*NUM_REQ-1:0] req_a,
  input  logic [FP16_W*NUM_REQ-1:0] req_b,
  output logic                      mul_start,
  output logic [FP16_W-1:0]         mul_a,
  output logic [FP16_W-1:0]         mul_b,
  input  logic                      mul_done,
  input  logic [FP16_W-1:0]         mul_result,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic [FP16_W-1:0]         resp_data,
  output logic                      resp_timeout,
  output logic                      busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  sched_state_t        state_q, state_d;
  logic [ID_W-1:0]     rr_ptr;
  logic [CNT_W-1:0]    cnt;
  logic [FP16_W-1:0]   a_q, b_q, res_q;
  logic [ID_W-1:0]     id_q;
  logic                tmo_q;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [ID_W-1:0]     arb_idx;
  logic                arb_any;
  logic                wd_expired;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  assign wd_expired = (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    req_ready    = '0;
    mul_start    = 1'b0;
    mul_a        = '0;
    mul_b        = '0;
    resp_valid   = 1'b0;
    resp_id      = '0;
    resp_data    = '0;
    resp_timeout = 1'b0;
    busy         = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          req_ready = arb_grant;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        mul_start = 1'b1;
        mul_a     = a_q;
        mul_b     = b_q;
        state_d   = WAIT;
      end
      WAIT: begin
        mul_a = a_q;
        mul_b = b_q;
        if (mul_done || wd_expired) state_d = RESPOND;
      end
      RESPOND: begin
        resp_valid   = 1'b1;
        resp_id      = id_q;
        resp_data    = res_q;
        resp_timeout = tmo_q;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_ptr  <= '0;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      id_q    <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            a_q  <= req_a[FP16_W*arb_idx +: FP16_W];
            b_q  <= req_b[FP16_W*arb_idx +: FP16_W];
            id_q <= arb_idx;
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          // a done arriving on the last watchdog cycle still wins over the timeout
          if (mul_done) begin
            res_q <= mul_result;
            tmo_q <= 1'b0;
          end else if (wd_expired) begin
            res_q <= FP16_QNAN;
            tmo_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESPOND: begin
          if (resp_ready)
            rr_ptr <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_mul_sched.sv
// Self-checking bench: transaction-level model of the scheduler plus a fake multiplier.
module tb_fp16_mul_sched;

  localparam int N   = 4;
  localparam int TMO = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_ready;
  logic [16*N-1:0]   req_a, req_b;
  logic              mul_start, mul_done;
  logic [15:0]       mul_a, mul_b, mul_result;
  logic              resp_valid, resp_ready, resp_timeout, busy;
  logic [1:0]        resp_id;
  logic [15:0]       resp_data;

  always #5 clk = ~clk;

  fp16_mul_sched #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_start(mul_start), .mul_a(mul_a),
    .mul_b(mul_b), .mul_done(mul_done), .mul_result(mul_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_timeout(resp_timeout), .busy(busy)
  );

  // exponent-add stand-in: exact for positive fp16 powers of two and 2.0*3.0
  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    return a + b - 16'h3C00;
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // counters owned by the compare process
  int checks = 0, errors = 0;
  int cyc = 0, resp_count = 0, grant_count = 0, start_cnt = 0;
  logic [N-1:0] accept_vec = '0;
  logic [15:0]  st_a = '0, st_b = '0;

  // knobs owned by the stimulus process
  int  lat_mode = 1, stim_to = 0, inj_req = 0, phase = 0;
  bit  spur_en = 0, hold_all = 0;
  int  lit_seq[8];
  int  lit_len = 0;
  bit  lit_rsp_on = 0, lit_tmo = 0;
  int  lit_id = 0, lit_lat = 0;
  logic [15:0] lit_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // compare process: the model tracks one transaction from grant to response handshake
  always @(negedge clk) begin : cmp
    int g, ptr, cur_id, grant_cyc, start_cyc, k, phase_seen, to_seen;
    bit inflight, started, have_exp, infl_old, hexp_old, prev_rv, exp_v;
    logic [15:0] cur_a, cur_b, exp_data;
    logic [N-1:0] one;
    bit exp_tmo;
    cyc++;
    if (stim_to != to_seen) begin
      checks++; errors++; to_seen = stim_to;
    end
    if (phase != phase_seen) begin
      k = 0; phase_seen = phase;
    end
    if (rst) begin
      inflight = 0; started = 0; have_exp = 0; ptr = 0; prev_rv = 0;
      accept_vec = '0; grant_count = resp_count;
    end else begin
      infl_old = inflight;
      hexp_old = have_exp;
      chk("busy", busy, infl_old);
      if (!infl_old) chk("mul_operands_idle", {mul_a, mul_b}, 32'h0);
      accept_vec = req_ready;
      if (!infl_old && req_valid != '0) begin
        g = pick(req_valid, ptr);
        one = 1;
        chk("grant", req_ready, one << g);
        if (k < lit_len) chk("lit_grant_order", g, lit_seq[k]);
        k++;
        inflight = 1; started = 0; have_exp = 0; cur_id = g; grant_cyc = cyc;
        cur_a = req_a[16*g +: 16]; cur_b = req_b[16*g +: 16];
        grant_count++;
      end else begin
        chk("no_grant", req_ready, '0);
      end
      chk("mul_start", mul_start, infl_old && cyc == grant_cyc + 1);
      if (mul_start && infl_old) begin
        started = 1; start_cyc = cyc;
        chk("mul_a", mul_a, cur_a);
        chk("mul_b", mul_b, cur_b);
        st_a = mul_a; st_b = mul_b;
        start_cnt++;
      end else if (infl_old && started && !hexp_old) begin
        chk("mul_operands_held", {mul_a, mul_b}, {cur_a, cur_b});
        if (mul_done) begin
          have_exp = 1; exp_data = mul_result; exp_tmo = 0;
        end else if (cyc == start_cyc + TMO) begin
          have_exp = 1; exp_data = 16'h7E00; exp_tmo = 1;
        end
      end
      exp_v = infl_old && hexp_old;
      chk("resp_valid", resp_valid, exp_v);
      if (resp_valid && exp_v) begin
        if (lit_rsp_on && !prev_rv) chk("lit_latency", cyc - start_cyc, lit_lat);
        chk("resp_id", resp_id, cur_id);
        chk("resp_data", resp_data, exp_data);
        chk("resp_timeout", resp_timeout, exp_tmo);
        if (resp_ready) begin
          if (lit_rsp_on) begin
            chk("lit_resp_id", resp_id, lit_id);
            chk("lit_resp_data", resp_data, lit_data);
            chk("lit_resp_timeout", resp_timeout, lit_tmo);
          end
          ptr = (cur_id + 1) % N;
          inflight = 0;
          resp_count++;
        end
      end
      prev_rv = resp_valid;
      if (inflight && cyc - grant_cyc > 200) begin
        checks++; errors++;
        $display("FAIL hang: no response for id %0d after 200 cycles", cur_id);
        inflight = 0; grant_count = resp_count;
      end
    end
  end

  // multiplier model: done after a chosen latency, plus optional spurious/stale pulses
  always @(posedge clk) begin : mulm
    int cd, seen, inj_done, r;
    logic [15:0] pa, pb;
    #2;
    mul_done = 1'b0;
    if (rst) begin
      cd = 0; seen = start_cnt;
    end else begin
      if (start_cnt != seen) begin
        seen = start_cnt; pa = st_a; pb = st_b;
        case (lat_mode)
          0: begin r = $urandom_range(1, 20); cd = (r <= 17) ? r : 0; end
          1: cd = 2;
          default: cd = 0;
        endcase
      end
      if (inj_req != inj_done) begin
        inj_done = inj_req; mul_done = 1'b1; mul_result = 16'h1234;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin mul_done = 1'b1; mul_result = fmul(pa, pb); end
      end else if (spur_en && $urandom_range(0, 15) == 0) begin
        mul_done = 1'b1; mul_result = 16'($urandom);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (accept_vec[i]) begin
        if (hold_all) begin
          req_a[16*i +: 16] = 16'($urandom);
          req_b[16*i +: 16] = 16'($urandom);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    req_valid[i] = 1'b1;
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic wait_resps(input int target, input int limit);
    int n = 0;
    while (resp_count < target && n < limit) begin tick(); n++; end
    if (resp_count < target) begin
      $display("FAIL wait_resp: got %0d responses expected %0d", resp_count, target);
      stim_to++;
    end
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (!(req_valid == '0 && grant_count == resp_count) && n < limit) begin tick(); n++; end
    if (n >= limit) begin
      $display("FAIL wait_idle: grants %0d responses %0d", grant_count, resp_count);
      stim_to++;
    end
  endtask

  initial begin
    int n, sc;
    rst = 1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1; mul_done = 0; mul_result = '0;
    repeat (3) tick();
    rst = 0;
    repeat (2) tick();

    // single request, done two cycles after start
    phase = 1; lit_rsp_on = 1; lit_id = 0; lit_data = 16'h4000; lit_tmo = 0; lit_lat = 3;
    set_req(0, 16'h3C00, 16'h4000);
    wait_resps(resp_count + 1, 50);
    lit_rsp_on = 0;
    tick();

    // fairness from a fresh pointer
    rst = 1; tick(); rst = 0; tick();
    lit_seq = '{0, 1, 2, 3, 0, 1, 0, 0}; lit_len = 6; phase = 2;
    hold_all = 1;
    for (int i = 0; i < N; i++) set_req(i, 16'($urandom), 16'($urandom));
    wait_resps(resp_count + 6, 200);
    hold_all = 0;
    wait_idle(200);

    // pointer wrap: serve id 2, then 1 and 3 compete
    lit_seq = '{2, 3, 1, 0, 0, 0, 0, 0}; lit_len = 3; phase = 3;
    set_req(2, 16'h4000, 16'h4000);
    wait_resps(resp_count + 1, 50);
    set_req(1, 16'h3C00, 16'h3C00);
    set_req(3, 16'h4400, 16'h3C00);
    wait_resps(resp_count + 2, 100);
    lit_len = 0;

    // watchdog, then a normal operation
    phase = 4; lat_mode = 2;
    lit_rsp_on = 1; lit_id = 0; lit_data = 16'h7E00; lit_tmo = 1; lit_lat = TMO + 1;
    set_req(0, 16'h4000, 16'h4000);
    wait_resps(resp_count + 1, 60);
    phase = 5; lat_mode = 1;
    lit_id = 1; lit_data = 16'h4600; lit_tmo = 0; lit_lat = 3;
    set_req(1, 16'h4000, 16'h4200);
    wait_resps(resp_count + 1, 50);
    lit_rsp_on = 0;

    // backpressure with all requests pending
    phase = 6; resp_ready = 0;
    for (int i = 0; i < N; i++) set_req(i, 16'($urandom), 16'($urandom));
    n = 0;
    while (!resp_valid && n < 50) begin tick(); n++; end
    if (!resp_valid) begin $display("FAIL backpressure: resp_valid never rose"); stim_to++; end
    repeat (10) tick();
    resp_ready = 1;
    wait_idle(200);

    // reset while waiting on the multiplier, then a stale done
    phase = 7; lat_mode = 2;
    sc = start_cnt;
    set_req(2, 16'h4000, 16'h4000);
    n = 0;
    while (start_cnt == sc && n < 20) begin tick(); n++; end
    if (start_cnt == sc) begin $display("FAIL reset_wait: mul_start never seen"); stim_to++; end
    repeat (3) tick();
    rst = 1; req_valid = '0;
    tick();
    rst = 0; inj_req++;
    repeat (4) tick();
    lat_mode = 1; lit_seq = '{0, 1, 2, 3, 0, 0, 0, 0}; lit_len = 4; phase = 8;
    for (int i = 0; i < N; i++) set_req(i, 16'($urandom), 16'($urandom));
    wait_idle(200);
    lit_len = 0;

    // randomized traffic: random latencies, missing and spurious dones, backpressure
    phase = 9; lat_mode = 0; spur_en = 1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      resp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0)
          set_req(i, 16'($urandom), 16'($urandom));
        else if (req_valid[i] && $urandom_range(0, 29) == 0)
          req_valid[i] = 1'b0;
      end
    end
    spur_en = 0; resp_ready = 1;
    wait_idle(400);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp16_mul_sched.md
Name: fp16_mul_sched

Overview:
- Round-robin scheduler that shares one half-precision multiplier datapath between NUM_REQ requesters.
- Accepts operand pairs over valid/ready and issues them to the multiplier with a start/done handshake.
- Returns each tagged product over valid/ready with backpressure, plus a watchdog that stops the controller hanging on a missing done.
- Sits between the issue logic of the FPU and the fp16 multiplier core.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- TIMEOUT, 15, cycles WAIT tolerates without mul_done before aborting (>=1).
- ID_W, $clog2(NUM_REQ), derived localparam, width of requester id.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  one-hot grant/accept.
- req_a  in  16*NUM_REQ  operand A; slot i at [16i+15:16i].
- req_b  in  16*NUM_REQ  operand B; same packing.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a  out  16  operand A to the multiplier.
- mul_b  out  16  operand B to the multiplier.
- mul_done  in  1  multiplier result-valid pulse.
- mul_result  in  16  multiplier product, sampled with mul_done.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  ID_W  index of the requester that owns the response.
- resp_data  out  16  fp16 product.
- resp_timeout  out  1  response was produced by the watchdog.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE, rr_ptr=0, counter=0, operand/result/id registers=0. All outputs 0 from the next cycle.
- Reset mid-operation abandons the transaction with no response. A stale mul_done after reset is ignored.
- IDLE:
  - If any req_valid is high, grant the first set bit scanning upward from rr_ptr with wrap.
  - req_ready[grant]=1 combinationally in the same cycle; the handshake completes there.
  - Capture req_a/req_b slot and grant id, then go to ISSUE. All other req_ready bits stay 0.
- ISSUE: mul_start=1 for exactly one cycle, counter cleared, go to WAIT.
- mul_a/mul_b are driven from the capture registers and held stable from ISSUE until WAIT exits; 0 in IDLE.
- WAIT:
  - mul_done=1: capture mul_result, resp_timeout=0, go to RESPOND.
  - No done, counter==TIMEOUT-1: resp_data=16'h7E00 (qNaN), resp_timeout=1, go to RESPOND.
  - Otherwise counter increments.
  - mul_done outside WAIT is ignored.
- RESPOND:
  - resp_valid=1; resp_id, resp_data and resp_timeout are held stable until resp_ready=1.
  - On handshake: rr_ptr = (grant+1) mod NUM_REQ, go to IDLE.
  - No req_ready is asserted in RESPOND, so at most one operation is in flight.
- Latency: the accept cycle is cycle 0, mul_start is cycle 1, and mul_done is seen earliest in cycle 2. resp_valid rises earliest in cycle 3.
- Minimum cycles per operation is 4 with resp_ready held high.
- rr_ptr updates only on response handshake, never on timeout-free idle cycles.
- Requesters hold valid and operands until ready. A valid dropped before grant is simply not arbitrated.
- Counter width is $clog2(TIMEOUT+1). No overflow is possible.
- resp_valid with resp_ready low for any duration: no state change, no outputs change.

Decomposition:
- Package fp16_mul_pkg holds:
  - sched_state_t enum {IDLE, ISSUE, WAIT, RESPOND};
  - FP16_W=16;
  - FP16_QNAN=16'h7E00.
- Sub-module rr_arbiter (params N), purely combinational:
  - inputs: request vector, pointer;
  - outputs: one-hot grant, grant index, any.
- The FSM, registers and watchdog stay in fp16_mul_sched.

Test Plan:
- Single request: only req0 valid, a=0x3C00, b=0x4000; multiplier model returns 0x4000 two cycles after start. Required: resp_valid with id=0, data=0x4000, timeout=0; mul_start pulses exactly once.
- Fairness: all four req_valid held high, resp_ready=1. Required: grants in order 0,1,2,3,0,1; no requester served twice before the others.
- Pointer wrap: after serving id 2, only req1 and req3 valid. Required: req3 granted first, then req1.
- Watchdog: mul_done never asserted, TIMEOUT=15. Required: resp_valid after 15 WAIT cycles with data=0x7E00, timeout=1; next request then served normally.
- Backpressure: resp_ready low for 10 cycles with other requests pending. Required: resp_valid/id/data stable, req_ready stays all-zero, one response on release.
- Reset in WAIT: assert rst, then pulse mul_done with 0x1234. Required: no resp_valid, busy=0, rr_ptr=0; next request granted from id 0.
